imem_fetch_ctrl: RTL and testbench

- Sequencer and arbiter for the single-port instruction memory (64 x 32-bit words, combinational read, word index = byte address [31:2]).
- Shares the memory port between a boot loader, which writes the program, and the fetch path.
- Owns the program counter and delivers {pc, instruction} pairs to the decode stage through a one-entry valid/ready output buffer.
- Supports control-flow redirect and halts on EBREAK or an out-of-range PC.

---
 rtl/imem_pkg.sv | 15 +
 rtl/imem_fetch_ctrl_out_buf.sv | 53 +++++
 rtl/imem_fetch_ctrl.sv | 157 +++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory fetch controller.
// Optional perf counters are enabled with IMEM_FETCH_PERF_EN.
package imem_pkg;

  localparam int          INSTR_W         = 32;
  localparam logic [31:0] HALT_INSTR_DFLT = 32'h0010_0073;
  localparam logic [31:0] RESET_PC_DFLT   = 32'h0000_0000;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/imem_fetch_ctrl_out_buf.sv
// One-entry valid/ready output register between fetch and decode.
// Flush drops the entry; load wins over a pending accept.
module imem_out_buf
  import imem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               load,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [31:0]        pc_in,
  input  logic               ready,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        pc
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0]        pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = instr_in;
      pc_d    = pc_in;
    end else if (ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Arbitrates the imem port between loader and fetch; owns PC and FSM.
// Define IMEM_FETCH_PERF_EN to add fetch_cnt/stall_cnt outputs.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int          DEPTH      = 64,
  parameter logic [31:0] RESET_PC   = RESET_PC_DFLT,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [31:0]        ld_addr,
  input  logic [31:0]        ld_data,
  input  logic               ld_done,
  output logic               imem_we,
  output logic [31:0]        imem_addr,
  output logic [31:0]        imem_wdata,
  input  logic [31:0]        imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [31:0]        pc_out,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
`ifdef IMEM_FETCH_PERF_EN
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        stall_cnt,
`endif
  output logic               halted,
  output logic               err
);

  localparam logic [31:0] LIMIT = 32'(DEPTH) << 2;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        err_q, err_d;
  logic        halted_q, halted_d;

  logic buf_flush, buf_load, buf_valid;
  logic ld_ok, fetch_opp, pc_ok;

  assign ld_ok     = (ld_addr[1:0] == 2'b00) && (ld_addr < LIMIT);
  assign fetch_opp = !buf_valid || instr_ready;
  assign pc_ok     = pc_q < LIMIT;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    err_d      = err_q;
    ld_ready   = 1'b0;
    imem_we    = 1'b0;
    imem_addr  = '0;
    imem_wdata = '0;
    buf_flush  = 1'b0;
    buf_load   = 1'b0;
    unique case (state_q)
      LOAD: begin
        ld_ready   = 1'b1;
        imem_addr  = ld_addr;
        imem_wdata = ld_data;
        imem_we    = ld_valid && ld_ok;
        if (ld_valid && !ld_ok) err_d = 1'b1;
        if (ld_done) begin
          state_d = RUN;
          pc_d    = RESET_PC;
        end
      end
      RUN: begin
        imem_addr = pc_q;
        if (redirect_valid) begin
          // redirect beats fetch: costs exactly one bubble
          buf_flush = 1'b1;
          pc_d      = {redirect_pc[31:2], 2'b00};
          if (redirect_pc[1:0] != 2'b00) err_d = 1'b1;
        end else if (fetch_opp) begin
          if (!pc_ok) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            buf_load = 1'b1;
            pc_d     = pc_q + 32'd4;
            if (imem_rdata == HALT_INSTR) state_d = HALT;
          end
        end
      end
      HALT: ;
      default: state_d = LOAD;
    endcase
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LOAD;
      pc_q     <= RESET_PC;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      err_q    <= err_d;
      halted_q <= halted_d;
    end
  end

  assign err    = err_q;
  assign halted = halted_q;

  imem_out_buf u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (buf_flush),
    .load     (buf_load),
    .instr_in (imem_rdata),
    .pc_in    (pc_q),
    .ready    (instr_ready),
    .valid    (buf_valid),
    .instr    (instr_out),
    .pc       (pc_out)
  );

  assign instr_valid = buf_valid;

`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        stall;

  assign stall = (state_q == RUN) && buf_valid && !instr_ready;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (buf_load && (fetch_cnt_q != '1))
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed plus randomized bench for imem_fetch_ctrl.
// Reference model tracks the accepted instruction stream at transaction level.
module tb_imem_fetch_ctrl;
  import imem_pkg::*;

  localparam int          DEPTH  = 64;
  localparam logic [31:0] LIMIT  = 32'(DEPTH * 4);
  localparam logic [31:0] HALT_W = 32'h0010_0073;

  logic        clk, rst;
  logic        ld_valid, ld_ready, ld_done;
  logic [31:0] ld_addr, ld_data;
  logic        imem_we;
  logic [31:0] imem_addr, imem_wdata, imem_rdata;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_out, pc_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted, err;
`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  imem_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .ld_done        (ld_done),
    .imem_we        (imem_we),
    .imem_addr      (imem_addr),
    .imem_wdata     (imem_wdata),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef IMEM_FETCH_PERF_EN
    .fetch_cnt      (fetch_cnt),
    .stall_cnt      (stall_cnt),
`endif
    .halted         (halted),
    .err            (err)
  );

  logic [31:0] mem   [DEPTH];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] prog  [4];

  assign imem_rdata = mem[imem_addr[7:2]];

  always @(posedge clk)
    if (imem_we) mem[imem_addr[7:2]] <= imem_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    ld_valid       = 1'b0;
    ld_addr        = '0;
    ld_data        = '0;
    ld_done        = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    logic ok;
    ok       = (a[1:0] == 2'b00) && (a < LIMIT);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    #1;
    chk("ld_we", {31'd0, imem_we}, {31'd0, ok});
    tick();
    ld_valid = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    if (ok) mem_m[a[7:2]] = d;
  endtask

  task automatic start();
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 4; i++) load(32'(i * 4), prog[i]);
  endtask

  logic [31:0] model_pc, tgt, w;
  logic        done, exp_err, redir;
  int          cnt, cyc, hidx;

  initial begin
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h0010_0073;

    // reset values
    rst = 1'b1;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #2;
    chk("rst_valid",  {31'd0, instr_valid}, 32'd0);
    chk("rst_instr",  instr_out, 32'd0);
    chk("rst_pc",     pc_out, 32'd0);
    chk("rst_err",    {31'd0, err}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_ldrdy",  {31'd0, ld_ready}, 32'd1);
    chk("rst_we",     {31'd0, imem_we}, 32'd0);
    chk("rst_addr",   imem_addr, 32'd0);
    chk("rst_wdata",  imem_wdata, 32'd0);

    // 1: load and run at full throughput
    do_reset();
    load_prog();
    instr_ready = 1'b1;
    start();
    chk("t1_valid0", {31'd0, instr_valid}, 32'd0);
    chk("t1_ldrdy",  {31'd0, ld_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_valid", {31'd0, instr_valid}, 32'd1);
      chk("t1_pc",    pc_out, 32'(i * 4));
      chk("t1_instr", instr_out, prog[i]);
      chk("t1_halt",  {31'd0, halted}, {31'd0, i == 3});
    end
    chk("t1_err", {31'd0, err}, 32'd0);
`ifdef IMEM_FETCH_PERF_EN
    chk("t1_fcnt", fetch_cnt, 32'd4);
`endif
    tick();
    chk("t1_drain", {31'd0, instr_valid}, 32'd0);
    chk("t1_hold",  {31'd0, halted}, 32'd1);

    // 2: backpressure at pc_out=4
    do_reset();
    load_prog();
    instr_ready = 1'b1;
    start();
    tick();
    tick();
    chk("t2_pc4", pc_out, 32'h4);
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_spc",   pc_out, 32'h4);
      chk("t2_sins",  instr_out, 32'h00A0_0113);
      chk("t2_sval",  {31'd0, instr_valid}, 32'd1);
      chk("t2_fetch", imem_addr, 32'h8);
    end
`ifdef IMEM_FETCH_PERF_EN
    chk("t2_scnt", stall_cnt, 32'd3);
`endif
    instr_ready = 1'b1;
    tick();
    chk("t2_pc8", pc_out, 32'h8);

    // 3: redirect, aligned then misaligned
    do_reset();
    load_prog();
    instr_ready = 1'b1;
    start();
    tick();
    chk("t3_pc0", pc_out, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8;
    tick();
    redirect_valid = 1'b0;
    chk("t3_bub", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("t3_pc8", pc_out, 32'h8);
    chk("t3_val", {31'd0, instr_valid}, 32'd1);
    chk("t3_err0", {31'd0, err}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hA;
    tick();
    redirect_valid = 1'b0;
    chk("t3_bub2", {31'd0, instr_valid}, 32'd0);
    chk("t3_err1", {31'd0, err}, 32'd1);
    tick();
    chk("t3_pcA", pc_out, 32'h8);
    chk("t3_insA", instr_out, prog[2]);

    // 4: bad loader writes
    do_reset();
    load(32'h102, 32'h1111_1111);
    chk("t4_err", {31'd0, err}, 32'd1);
    load(32'h100, 32'h2222_2222);
    load(32'h10, 32'hDEAD_BEEF);
    chk("t4_mem", mem[4], 32'hDEAD_BEEF);
    chk("t4_err2", {31'd0, err}, 32'd1);

    // 5: run off the end of memory
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      load(32'(i * 4), 32'h13 | 32'(i << 7));
    instr_ready = 1'b1;
    start();
    cnt = 0;
    cyc = 0;
    while (!halted && cyc < 200) begin
      tick();
      cyc++;
      if (instr_valid) begin
        chk("t5_pc", pc_out, 32'(cnt * 4));
        cnt++;
      end
    end
    chk("t5_cnt",  32'(cnt), 32'd64);
    chk("t5_halt", {31'd0, halted}, 32'd1);
    chk("t5_err",  {31'd0, err}, 32'd1);
    chk("t5_val",  {31'd0, instr_valid}, 32'd0);

    // 6: async reset between edges, from HALT and mid-RUN
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_hhalt", {31'd0, halted}, 32'd0);
    chk("t6_herr",  {31'd0, err}, 32'd0);
    chk("t6_hldr",  {31'd0, ld_ready}, 32'd1);
    do_reset();
    load_prog();
    instr_ready = 1'b1;
    start();
    tick();
    chk("t6_pre", {31'd0, instr_valid}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_val",  {31'd0, instr_valid}, 32'd0);
    chk("t6_halt", {31'd0, halted}, 32'd0);
    chk("t6_ldr",  {31'd0, ld_ready}, 32'd1);
    chk("t6_pc",   pc_out, 32'd0);

    // randomized programs, backpressure and redirects
    for (int it = 0; it < 4; it++) begin
      do_reset();
      hidx = (it % 2 == 0) ? $urandom_range(8, DEPTH - 1) : -1;
      for (int i = 0; i < DEPTH; i++) begin
        w = $urandom;
        if (w == HALT_W) w = w ^ 32'h1;
        if (i == hidx) w = HALT_W;
        load(32'(i * 4), w);
      end
      start();
      model_pc = 32'd0;
      exp_err  = 1'b0;
      done     = 1'b0;
      cyc      = 0;
      while (!done && cyc < 5000) begin
        redir = !halted && ($urandom_range(0, 39) == 0);
        if (redir) begin
          tgt            = 32'($urandom_range(0, DEPTH * 4 - 1));
          instr_ready    = 1'b0;
          redirect_valid = 1'b1;
          redirect_pc    = tgt;
        end else begin
          redirect_valid = 1'b0;
          instr_ready    = ($urandom_range(0, 3) != 0);
        end
        #1;
        if (instr_valid && instr_ready) begin
          chk("rnd_pc",  pc_out, model_pc);
          chk("rnd_ins", instr_out, mem_m[model_pc[7:2]]);
          if (mem_m[model_pc[7:2]] == HALT_W) done = 1'b1;
          model_pc = model_pc + 32'd4;
          if (model_pc == LIMIT) begin
            done    = 1'b1;
            exp_err = 1'b1;
          end
        end
        if (redir) begin
          model_pc = tgt & ~32'd3;
          if (tgt[1:0] != 2'b00) exp_err = 1'b1;
        end
        tick();
        cyc++;
      end
      redirect_valid = 1'b0;
      instr_ready    = 1'b1;
      chk("rnd_done", {31'd0, done}, 32'd1);
      tick();
      tick();
      chk("rnd_halt", {31'd0, halted}, 32'd1);
      chk("rnd_val",  {31'd0, instr_valid}, 32'd0);
      chk("rnd_err",  {31'd0, err}, {31'd0, exp_err});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
